// File: rtl/mpu_mult_scheduler_pkg.sv
// Shared types and defaults for the MPU matrix-multiply scheduler.
package mpu_mult_scheduler_pkg;

  // Global defaults: word width and matrix dimensions.
  localparam int FP = 32;
  localparam int M  = 3;
  localparam int N  = 3;

  localparam logic [31:0] POS_ZERO_32BIT = 32'h0000_0000;

  typedef logic [31:0] float_sp;

  typedef enum logic [1:0] {
    FPU_NOP = 2'd0,
    FPU_ADD = 2'd1,
    FPU_MUL = 2'd2,
    FPU_FMA = 2'd3
  } fpu_instruction_e;

  typedef enum logic [2:0] {
    SCHED_IDLE  = 3'd0,
    SCHED_ISSUE = 3'd1,
    SCHED_WAIT  = 3'd2,
    SCHED_WRITE = 3'd3,
    SCHED_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/mpu_mult_scheduler.sv
// Sequences C = A x B through one shared FMA unit, one accumulate at a time,
// walking output elements in row-major order.
module mpu_mult_scheduler #(
  parameter int FP = mpu_mult_scheduler_pkg::FP,
  parameter int M  = mpu_mult_scheduler_pkg::M,
  parameter int N  = mpu_mult_scheduler_pkg::N
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [0:M*N-1][FP-1:0]           matrix_a_in,
  input  logic [0:M*N-1][FP-1:0]           matrix_b_in,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [0:M*N-1][FP-1:0]           matrix_out,
  output logic                             fma_req_valid,
  input  logic                             fma_req_ready,
  output mpu_mult_scheduler_pkg::fpu_instruction_e fma_op,
  output logic [FP-1:0]                    fma_a,
  output logic [FP-1:0]                    fma_b,
  output logic [FP-1:0]                    fma_c,
  input  logic                             fma_resp_valid,
  input  logic [FP-1:0]                    fma_resp_y,
  input  logic                             fma_resp_error
);
  import mpu_mult_scheduler_pkg::*;

  localparam int IW   = (M > 1) ? $clog2(M) : 1;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int IDXW = (M * N > 1) ? $clog2(M * N) : 1;

  sched_state_e             state;
  logic [0:M*N-1][FP-1:0]   a_q, b_q, c_q;
  logic [IW-1:0]            i;
  logic [KW-1:0]            j, k;
  logic [FP-1:0]            acc;
  logic                     err_q;
  logic [IDXW-1:0]          a_idx, b_idx, c_idx;

  // Flat indices for A[i][k], B[k][j] and C[i][j].
  always_comb begin
    a_idx = IDXW'(int'(i) * N + int'(k));
    b_idx = IDXW'(int'(k) * N + int'(j));
    c_idx = IDXW'(int'(i) * N + int'(j));
  end

  // Scheduler FSM: latch operands, issue/await each FMA, write back, finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCHED_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= POS_ZERO_32BIT;
      err_q <= 1'b0;
    end else begin
      case (state)
        SCHED_IDLE: if (start) begin
          a_q   <= matrix_a_in;
          b_q   <= matrix_b_in;
          c_q   <= '0;
          err_q <= 1'b0;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          acc   <= POS_ZERO_32BIT;
          state <= SCHED_ISSUE;
        end
        SCHED_ISSUE: if (fma_req_ready) state <= SCHED_WAIT;
        SCHED_WAIT: if (fma_resp_valid) begin
          acc <= fma_resp_y;
          if (fma_resp_error) begin
            err_q <= 1'b1;
            state <= SCHED_DONE;
          end else if (int'(k) < N - 1) begin
            k     <= k + 1'b1;
            state <= SCHED_ISSUE;
          end else begin
            state <= SCHED_WRITE;
          end
        end
        SCHED_WRITE: begin
          c_q[c_idx] <= acc;
          acc        <= POS_ZERO_32BIT;
          k          <= '0;
          if (int'(i) == M - 1 && int'(j) == N - 1) begin
            state <= SCHED_DONE;
          end else begin
            if (int'(j) == N - 1) begin
              j <= '0;
              i <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
            state <= SCHED_ISSUE;
          end
        end
        SCHED_DONE: state <= SCHED_IDLE;
        default:    state <= SCHED_IDLE;
      endcase
    end
  end

  // Status and request outputs decode directly from state; operands are
  // zeroed while no request is valid so the bus is quiet between ops.
  always_comb begin
    busy          = (state == SCHED_ISSUE) || (state == SCHED_WAIT) || (state == SCHED_WRITE);
    done          = (state == SCHED_DONE);
    error         = err_q;
    matrix_out    = c_q;
    fma_req_valid = (state == SCHED_ISSUE);
    fma_op        = fma_req_valid ? FPU_FMA : FPU_NOP;
    fma_a         = fma_req_valid ? a_q[a_idx] : '0;
    fma_b         = fma_req_valid ? b_q[b_idx] : '0;
    fma_c         = fma_req_valid ? acc : '0;
  end

endmodule

// File: tb/tb_mpu_mult_scheduler.sv
// Scoreboard bench for mpu_mult_scheduler with a behavioural FMA responder.
module tb_mpu_mult_scheduler;
  import mpu_mult_scheduler_pkg::*;

  localparam int E = M * N;
  typedef logic [0:E-1][31:0] mat_t;
  typedef int imat_t[E];
  typedef struct { mat_t c; logic err; } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  mat_t matrix_a_in = '0, matrix_b_in = '0, matrix_out;
  logic busy, done, error, fma_req_valid;
  logic fma_req_ready = 1'b0, fma_resp_valid = 1'b0, fma_resp_error = 1'b0;
  fpu_instruction_e fma_op;
  logic [31:0] fma_a, fma_b, fma_c, fma_resp_y = '0;

  mpu_mult_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .matrix_a_in(matrix_a_in), .matrix_b_in(matrix_b_in),
    .busy(busy), .done(done), .error(error), .matrix_out(matrix_out),
    .fma_req_valid(fma_req_valid), .fma_req_ready(fma_req_ready), .fma_op(fma_op),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_resp_valid(fma_resp_valid), .fma_resp_y(fma_resp_y), .fma_resp_error(fma_resp_error)
  );

  always #5 clk = ~clk;

  exp_t scb[$];
  int pass_cnt = 0, chk_cnt = 0;
  int cyc = 0, hs_cnt = 0, resp_cnt = 0, done_cnt = 0, done_cyc = 0;
  int lat = 1, err_at = 0, due = 0;
  bit rand_ready = 0, pend = 0, outstanding = 0, stalled = 0;
  logic [31:0] ra, rb, rc, sa, sbv, scv;
  logic [31:0] log_a[$], log_b[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Integer <-> single-precision encoding; exact for the small integers used here.
  function automatic logic [31:0] i2f(int v);
    int a, p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int b = 0; b < 31; b++) if (a[b]) p = b;
    r[31]    = (v < 0);
    r[30:23] = 8'(p + 127);
    r[22:0]  = 23'(a << (23 - p));
    return r;
  endfunction

  function automatic int f2i(logic [31:0] f);
    int e, m;
    if (f[30:0] == 0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >>> (23 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic mat_t to_mat(imat_t x);
    mat_t r;
    for (int n = 0; n < E; n++) r[n] = i2f(x[n]);
    return r;
  endfunction

  function automatic mat_t matmul(imat_t a, imat_t b);
    imat_t c;
    for (int r = 0; r < M; r++)
      for (int q = 0; q < N; q++) begin
        c[r*N+q] = 0;
        for (int t = 0; t < N; t++) c[r*N+q] += a[r*N+t] * b[t*N+q];
      end
    return to_mat(c);
  endfunction

  // FMA responder, protocol checks and scoreboard monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 0; outstanding = 0; stalled = 0;
      fma_resp_valid = 0; fma_resp_error = 0; fma_req_ready = 0;
    end else begin
      fma_resp_valid = 0; fma_resp_error = 0; fma_resp_y = '0;
      if (pend && cyc == due) begin
        pend = 0; outstanding = 0; resp_cnt++;
        fma_resp_valid = 1;
        fma_resp_y = i2f(f2i(ra) * f2i(rb) + f2i(rc));
        fma_resp_error = (resp_cnt == err_at);
      end
      if (stalled) begin
        chk("hold_valid", {31'b0, fma_req_valid}, 32'd1);
        chk("hold_a", fma_a, sa);
        chk("hold_b", fma_b, sbv);
        chk("hold_c", fma_c, scv);
      end
      fma_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fma_req_valid && fma_req_ready) begin
        chk("one_outstanding", {31'b0, outstanding}, 32'd0);
        chk("op_fma", {30'b0, fma_op}, {30'b0, FPU_FMA});
        hs_cnt++;
        log_a.push_back(fma_a); log_b.push_back(fma_b);
        ra = fma_a; rb = fma_b; rc = fma_c;
        pend = 1; outstanding = 1; due = cyc + lat; stalled = 0;
      end else if (fma_req_valid) begin
        stalled = 1; sa = fma_a; sbv = fma_b; scv = fma_c;
      end else begin
        stalled = 0;
      end
    end
    if (done) begin
      exp_t e;
      done_cnt++; done_cyc = cyc;
      chk("busy_low_at_done", {31'b0, busy}, 32'd0);
      chk("done_expected", {31'b0, scb.size() != 0}, 32'd1);
      if (scb.size() != 0) begin
        e = scb.pop_front();
        for (int n = 0; n < E; n++) chk($sformatf("c[%0d]", n), matrix_out[n], e.c[n]);
        chk("error_flag", {31'b0, error}, {31'b0, e.err});
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic start_run(mat_t a, mat_t b, exp_t e, output int sc);
    matrix_a_in = a; matrix_b_in = b; start = 1;
    sc = cyc;
    scb.push_back(e);
    tick();
    start = 0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(int prev);
    int n = 0;
    while (done_cnt == prev && n < 5000) begin tick(); n++; end
    chk("done_seen", {31'b0, done_cnt > prev}, 32'd1);
    tick();
  endtask

  initial begin
    imat_t id, seq, ra_i, rb_i;
    exp_t e;
    int sc, d0, n;
    for (int q = 0; q < E; q++) begin
      seq[q] = q + 1;
      id[q]  = (q / N == q % N) ? 1 : 0;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_valid", {31'b0, fma_req_valid}, 32'd0);
    chk("rst_op", {30'b0, fma_op}, {30'b0, FPU_NOP});
    chk("rst_out_zero", {31'b0, matrix_out == '0}, 32'd1);
    rst = 0;
    tick();

    // Identity x B, fixed latency 1: result is B, done after 64 cycles
    e.c = to_mat(seq); e.err = 0;
    d0 = done_cnt;
    start_run(to_mat(id), to_mat(seq), e, sc);
    wait_done(d0);
    chk("latency_64", 32'(done_cyc - sc), 32'd64);

    // A = B = 1..9: handshake count and k-ordering for C[0]
    log_a.delete(); log_b.delete(); hs_cnt = 0;
    e.c = matmul(seq, seq); e.err = 0;
    d0 = done_cnt;
    start_run(to_mat(seq), to_mat(seq), e, sc);
    wait_done(d0);
    chk("c0_literal", matrix_out[0], 32'h41F0_0000);
    chk("handshakes_27", 32'(hs_cnt), 32'd27);
    chk("k0_a", log_a[0], i2f(1)); chk("k0_b", log_b[0], i2f(1));
    chk("k1_a", log_a[1], i2f(2)); chk("k1_b", log_b[1], i2f(4));
    chk("k2_a", log_a[2], i2f(3)); chk("k2_b", log_b[2], i2f(7));

    // Random backpressure and latency, random operands
    rand_ready = 1;
    for (int r = 0; r < 6; r++) begin
      lat = int'($urandom_range(1, 5));
      for (int q = 0; q < E; q++) begin
        ra_i[q] = (r == 0) ? seq[q] : int'($urandom_range(0, 16)) - 8;
        rb_i[q] = (r == 0) ? seq[q] : int'($urandom_range(0, 16)) - 8;
      end
      e.c = matmul(ra_i, rb_i); e.err = 0;
      d0 = done_cnt;
      start_run(to_mat(ra_i), to_mat(rb_i), e, sc);
      wait_done(d0);
    end
    rand_ready = 0; lat = 1;

    // Error on the 5th response: only C[0] written, no further requests
    hs_cnt = 0; resp_cnt = 0; err_at = 5;
    e.c = '0; e.c[0] = i2f(30); e.err = 1;
    d0 = done_cnt;
    start_run(to_mat(seq), to_mat(seq), e, sc);
    wait_done(d0);
    repeat (10) tick();
    chk("err_no_6th_req", 32'(hs_cnt), 32'd5);
    chk("err_held", {31'b0, error}, 32'd1);
    err_at = 0;

    // Reset at the 10th request: aborts silently, then a clean rerun
    hs_cnt = 0;
    e.c = matmul(seq, seq); e.err = 0;
    start_run(to_mat(seq), to_mat(seq), e, sc);
    n = 0;
    while (hs_cnt < 10 && n < 2000) begin tick(); n++; end
    chk("reached_10th_req", 32'(hs_cnt), 32'd10);
    rst = 1;
    scb.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, fma_req_valid}, 32'd0);
    chk("abort_a", fma_a, 32'h0);
    chk("abort_out_zero", {31'b0, matrix_out == '0}, 32'd1);
    tick(); tick();
    rst = 0;
    repeat (20) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    start_run(to_mat(seq), to_mat(seq), e, sc);
    wait_done(d0);

    // Start while busy with other operands is ignored
    e.c = matmul(seq, seq); e.err = 0;
    d0 = done_cnt;
    start_run(to_mat(seq), to_mat(seq), e, sc);
    repeat (5) tick();
    matrix_a_in = to_mat(id); start = 1;
    tick();
    start = 0;
    wait_done(d0);
    repeat (20) tick();
    chk("single_done", 32'(done_cnt), 32'(d0 + 1));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
